// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite SRAM model: response codes, FSM encoding
// and the byte-strobe merge used by the storage array.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_t;

    // Sized for the widest legal bus; narrower callers zero-extend and slice.
    function automatic logic [63:0] strb_merge(
        input logic [63:0] i_old,
        input logic [63:0] i_new,
        input logic [7:0]  i_strb
    );
        logic [63:0] w_res;
        for (int b = 0; b < 8; b++) begin
            w_res[b*8 +: 8] = i_strb[b] ? i_new[b*8 +: 8] : i_old[b*8 +: 8];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Word-addressed storage with byte-enabled synchronous write and a registered
// read port; the read register can be loaded with zero for error responses.
module sram_array
    import axi_lite_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_widx,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [DATA_W/8-1:0]        i_wstrb,
    input  logic                       i_re,
    input  logic                       i_rclr,
    input  logic [$clog2(DEPTH)-1:0]   i_ridx,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [63:0]       w_merged;

    assign w_merged = strb_merge(64'(r_mem[i_widx]), 64'(i_wdata), 8'(i_wstrb));

    // Contents are deliberately not reset so they survive a bus reset.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_widx] <= w_merged[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     o_rdata <= '0;
        else if (i_re) o_rdata <= i_rclr ? '0 : r_mem[i_ridx];
    end

endmodule

// File: rtl/axi_lite_sram.sv
// AXI-lite slave SRAM with fixed wait states, one outstanding transaction and
// alternating read/write priority under contention.
module axi_lite_sram_ws
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int         OFF = $clog2(DATA_W/8);
    localparam int         IW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t              r_state, w_next;
    logic [3:0]          r_cnt;
    logic [IW-1:0]       r_idx;
    logic                r_oor;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_last_wr;
    logic [1:0]          r_rresp, r_bresp;

    logic [ADDR_W-1:0]   w_ar_word, w_aw_word;
    logic                w_ar_oor, w_aw_oor, w_grant_rd, w_grant_wr, w_idle;
    logic                w_rd_enter, w_wr_enter;
    logic [IW-1:0]       w_ridx, w_widx;
    logic                w_roor, w_woor;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W/8-1:0] w_wstrb;

    // Byte-offset bits drop out here, so misaligned addresses hit the containing word.
    assign w_ar_word  = araddr >> OFF;
    assign w_aw_word  = awaddr >> OFF;
    assign w_ar_oor   = w_ar_word >= ADDR_W'(DEPTH);
    assign w_aw_oor   = w_aw_word >= ADDR_W'(DEPTH);

    assign w_idle     = (r_state == IDLE);
    assign w_grant_rd = arvalid && !(awvalid && wvalid && !r_last_wr);
    assign w_grant_wr = awvalid && wvalid && !(arvalid && r_last_wr);

    // With zero latency the response is entered on the accept edge, so the
    // array must see the live request rather than the latched copy.
    assign w_ridx     = w_idle ? w_ar_word[IW-1:0] : r_idx;
    assign w_roor     = w_idle ? w_ar_oor          : r_oor;
    assign w_widx     = w_idle ? w_aw_word[IW-1:0] : r_idx;
    assign w_woor     = w_idle ? w_aw_oor          : r_oor;
    assign w_wdata    = w_idle ? wdata             : r_wdata;
    assign w_wstrb    = w_idle ? wstrb             : r_wstrb;
    assign w_rd_enter = (w_next == RD_RESP) && (r_state != RD_RESP);
    assign w_wr_enter = (w_next == WR_RESP) && (r_state != WR_RESP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_rd)      w_next = (LATENCY == 0) ? RD_RESP : RD_WAIT;
                else if (w_grant_wr) w_next = (LATENCY == 0) ? WR_RESP : WR_WAIT;
            end
            RD_WAIT: if (r_cnt == 4'd0) w_next = RD_RESP;
            RD_RESP: if (rready)        w_next = IDLE;
            WR_WAIT: if (r_cnt == 4'd0) w_next = WR_RESP;
            WR_RESP: if (bready)        w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        rvalid  = 1'b0;
        bvalid  = 1'b0;
        case (r_state)
            IDLE: begin
                arready = w_grant_rd;
                awready = w_grant_wr;
                wready  = w_grant_wr;
            end
            RD_RESP: rvalid = 1'b1;
            WR_RESP: bvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_oor     <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_last_wr <= 1'b1;
            r_rresp   <= RESP_OKAY;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (w_idle && w_grant_rd) begin
                r_idx     <= w_ar_word[IW-1:0];
                r_oor     <= w_ar_oor;
                r_cnt     <= LAT;
                r_last_wr <= 1'b0;
            end else if (w_idle && w_grant_wr) begin
                r_idx     <= w_aw_word[IW-1:0];
                r_oor     <= w_aw_oor;
                r_wdata   <= wdata;
                r_wstrb   <= wstrb;
                r_cnt     <= LAT;
                r_last_wr <= 1'b1;
            end else if ((r_state == RD_WAIT || r_state == WR_WAIT) && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_rd_enter) r_rresp <= w_roor ? RESP_SLVERR : RESP_OKAY;
            if (w_wr_enter) r_bresp <= w_woor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    assign rresp = r_rresp;
    assign bresp = r_bresp;

    sram_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .i_we    (w_wr_enter && !w_woor),
        .i_widx  (w_widx),
        .i_wdata (w_wdata),
        .i_wstrb (w_wstrb),
        .i_re    (w_rd_enter),
        .i_rclr  (w_roor),
        .i_ridx  (w_ridx),
        .o_rdata (rdata)
    );

endmodule

// File: tb/tb_axi_lite_sram_ws.sv
// Randomized scoreboard bench for axi_lite_sram_ws: drivers push expected
// responses, a negedge monitor checks data, response, latency and stability.
module tb_axi_lite_sram_ws;

    localparam int AW = 64, DW = 64, DEPTH = 1024, LAT = 2;

    logic          clk = 1'b0, rstn = 1'b1;
    logic [AW-1:0] araddr = '0, awaddr = '0;
    logic          arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
    logic          rready = 1'b1, bready = 1'b1;
    logic [DW-1:0] wdata = '0, rdata;
    logic [7:0]    wstrb = '0;
    logic          arready, awready, wready, rvalid, bvalid;
    logic [1:0]    rresp, bresp;

    axi_lite_sram_ws #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        int          due;
    } exp_t;

    exp_t        rq[$], bq[$];
    logic [63:0] mem_m [longint];
    int          n_cmp = 0, n_bad = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: begin rready = 1'b1; bready = 1'b1; end
            1: begin rready = ($urandom_range(0, 3) != 0); bready = ($urandom_range(0, 3) != 0); end
            default: begin rready = 1'b0; bready = 1'b0; end
        endcase
    end

    // Reference behaviour: response is valid LAT+1 edges after the accept edge.
    function automatic exp_t model_rd(input logic [63:0] a);
        exp_t   e;
        longint w = longint'(a >> 3);
        e.due = cyc + LAT + 2;
        if (w >= DEPTH) begin
            e.data = '0; e.resp = 2'b10;
        end else begin
            e.data = mem_m.exists(w) ? mem_m[w] : 64'h0; e.resp = 2'b00;
        end
        return e;
    endfunction

    function automatic exp_t model_wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        exp_t        e;
        longint      w = longint'(a >> 3);
        logic [63:0] v;
        e.due  = cyc + LAT + 2;
        e.data = '0;
        if (w >= DEPTH) begin
            e.resp = 2'b10;
        end else begin
            e.resp = 2'b00;
            v = mem_m.exists(w) ? mem_m[w] : 64'h0;
            for (int b = 0; b < 8; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
            mem_m[w] = v;
        end
        return e;
    endfunction

    // Monitor: checks against the queue heads, independent of the drivers.
    logic        pr_v = 0, pr_h = 0, pb_v = 0, pb_h = 0;
    logic [63:0] pr_d = '0;
    logic [1:0]  pr_r = '0, pb_r = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            pr_v = 0; pr_h = 0; pb_v = 0; pb_h = 0;
        end else begin
            if (pr_h) begin
                chk("r_hold_valid", rvalid, 1);
                chk("r_hold_data", rdata, pr_d);
                chk("r_hold_resp", rresp, pr_r);
            end
            if (rvalid && !pr_v) begin
                if (rq.size() == 0) tmo("r_unexpected_no_pending_read");
                else chk("r_latency", cyc, rq[0].due);
            end
            if (rvalid && rready && rq.size() != 0) begin
                e = rq.pop_front();
                chk("r_data", rdata, e.data);
                chk("r_resp", rresp, e.resp);
            end
            pr_v = rvalid; pr_h = rvalid && !rready; pr_d = rdata; pr_r = rresp;

            if (pb_h) begin
                chk("b_hold_valid", bvalid, 1);
                chk("b_hold_resp", bresp, pb_r);
            end
            if (bvalid && !pb_v) begin
                if (bq.size() == 0) tmo("b_unexpected_no_pending_write");
                else chk("b_latency", cyc, bq[0].due);
            end
            if (bvalid && bready && bq.size() != 0) begin
                e = bq.pop_front();
                chk("b_resp", bresp, e.resp);
            end
            pb_v = bvalid; pb_h = bvalid && !bready; pb_r = bresp;
        end
    end

    task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        bit ok = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (awready && wready) ok = 1;
        end
        if (!ok) tmo("aw_handshake");
        else bq.push_back(model_wr(a, d, s));
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (bvalid && bready) ok = 1;
            end
            if (!ok) tmo("b_handshake");
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input logic [63:0] a);
        bit ok = 0;
        araddr = a; arvalid = 1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (arready) ok = 1;
        end
        if (!ok) tmo("ar_handshake");
        else rq.push_back(model_rd(a));
        @(posedge clk); #1;
        arvalid = 0;
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (rvalid && rready) ok = 1;
            end
            if (!ok) tmo("r_handshake");
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_arready"}, arready, 0);
        chk({tag, "_awready"}, awready, 0);
        chk({tag, "_wready"},  wready,  0);
        chk({tag, "_rvalid"},  rvalid,  0);
        chk({tag, "_bvalid"},  bvalid,  0);
        chk({tag, "_rdata"},   rdata,   0);
        chk({tag, "_rresp"},   rresp,   0);
        chk({tag, "_bresp"},   bresp,   0);
    endtask

    task automatic hold_test(input bit is_wr);
        ready_mode = 2;
        fork
            if (is_wr) wr(64'h10, 64'hCAFE_F00D_0BAD_BEEF, 8'hF0);
            else       rd(64'h10);
            begin
                bit seen = 0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (is_wr ? bvalid : rvalid) seen = 1;
                end
                repeat (5) @(negedge clk);
                ready_mode = 0;
            end
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_wr, got_wr, ok;
        #2 rstn = 0;
        #1 chk_reset("reset");
        repeat (3) @(negedge clk);
        rstn = 1;
        @(posedge clk); #1;

        wr(64'h10, 64'h1122_3344_5566_7788, 8'hFF);
        rd(64'h10);
        wr(64'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        rd(64'h10);
        wr(64'h13, 64'h5555_5555_5555_5555, 8'h00);
        rd(64'h17);

        wr(64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF);
        rd(64'h2000);
        wr(64'h2000, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
        rd(64'h0);

        hold_test(0);
        hold_test(1);
        rd(64'h10);

        for (int w = 0; w < 16; w++) wr(64'(w * 8), {$urandom, $urandom}, 8'hFF);
        ready_mode = 1;
        for (int n = 0; n < 60; n++) begin
            logic [63:0] a;
            if ($urandom_range(0, 7) == 0) a = 64'((DEPTH + $urandom_range(0, 100)) * 8);
            else a = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) rd(a);
            else wr(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        end
        ready_mode = 0;
        @(posedge clk); #1;

        // Reset while a write to word 3 is still waiting for its commit edge.
        awaddr = 64'h18; wdata = ~mem_m[3]; wstrb = 8'hFF; awvalid = 1; wvalid = 1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (awready && wready) ok = 1;
        end
        if (!ok) tmo("aw_handshake_pre_reset");
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        #2 rstn = 0;
        #1 chk_reset("midreset");
        repeat (2) @(negedge clk);
        rstn = 1;
        @(posedge clk); #1;

        // Contention straight after reset: grants alternate starting with read.
        exp_wr = 1;
        araddr = 64'h28; awaddr = 64'h30; wdata = {$urandom, $urandom}; wstrb = 8'hFF;
        arvalid = 1; awvalid = 1; wvalid = 1;
        for (int n = 0; n < 4; n++) begin
            ok = 0;
            got_wr = 0;
            for (int i = 0; i < 100 && !ok; i++) begin
                @(negedge clk);
                if (arready || awready) begin
                    ok = 1;
                    got_wr = awready;
                end
            end
            if (!ok) tmo("contention_handshake");
            else begin
                chk($sformatf("grant_%0d_is_write", n), got_wr, !exp_wr);
                if (got_wr) bq.push_back(model_wr(awaddr, wdata, wstrb));
                else        rq.push_back(model_rd(araddr));
                exp_wr = got_wr;
            end
            @(posedge clk); #1;
            if (got_wr) wdata = {$urandom, $urandom};
        end
        arvalid = 0; awvalid = 0; wvalid = 0;
        for (int i = 0; i < 200 && (rq.size() != 0 || bq.size() != 0); i++) @(negedge clk);
        @(posedge clk); #1;

        rd(64'h18);

        for (int i = 0; i < 200 && (rq.size() != 0 || bq.size() != 0); i++) @(negedge clk);
        chk("read_queue_drained", rq.size(), 0);
        chk("write_queue_drained", bq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
